// File: rtl/spi_mem_pkg.sv
// rtl/spi_mem_pkg.sv - shared constants, state encoding and frame sizing for the SPI memory controller
package spi_mem_pkg;

    localparam logic [7:0] SPI_CMD_READ  = 8'h03;
    localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SETUP,
        SHIFT,
        HOLD,
        DONE
    } state_t;

    function automatic int unsigned nbits(input int unsigned addr_w, input int unsigned nbytes);
        return 8 + addr_w + 8 * nbytes;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// rtl/spi_clk_div.sv - SCLK generator: DIV cycles low then DIV cycles high per bit, cleared while disabled
module spi_clk_div #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    output logic o_sclk,
    output logic o_rise_tick,
    output logic o_fall_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_phase;
    logic          w_wrap;

    assign w_wrap = (r_cnt == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || !i_en) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (w_wrap) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + CW'(1);
        end
    end

    // Ticks flag the clk edge on which the registered sclk level flips
    assign o_sclk      = r_phase;
    assign o_rise_tick = i_en & w_wrap & ~r_phase;
    assign o_fall_tick = i_en & w_wrap &  r_phase;

endmodule

// File: rtl/spi_mem_ctrl.sv
// rtl/spi_mem_ctrl.sv - parametrised SPI flash/RAM controller with request handshake and error response
module spi_mem_ctrl #(
    parameter int NUM_CS    = 2,
    parameter int ADDR_W    = 24,
    parameter int DIV       = 1,
    parameter int MAX_BYTES = 4,
    parameter int CSW       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [CSW-1:0]    req_cs,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_nbytes,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [31:0]       rsp_rdata,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_CS-1:0] cs_n
);

    import spi_mem_pkg::*;

    localparam int DW     = 8 * MAX_BYTES;
    localparam int SR_W   = 8 + ADDR_W + DW;
    localparam int NB_MAX = int'(nbits(ADDR_W, MAX_BYTES));
    localparam int BW     = $clog2(NB_MAX + 1);

    state_t              r_state;
    state_t              w_next;
    logic                r_write;
    logic [CSW-1:0]      r_cs;
    logic [ADDR_W-1:0]   r_addr;
    logic [2:0]          r_nbytes;
    logic [31:0]         r_wdata;
    logic                r_err;
    logic [SR_W-1:0]     r_shift;
    logic [31:0]         r_rx;
    logic [BW-1:0]       r_bit;
    logic [NUM_CS-1:0]   r_cs_n;
    logic [31:0]         r_rdata;
    logic                w_illegal;
    logic                w_last;
    logic                w_clk_en;
    logic                w_rise;
    logic                w_fall;
    logic [DW-1:0]       w_data_field;
    logic [31:0]         w_rdata;

    spi_clk_div #(.DIV(DIV)) u_clk_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_en        (w_clk_en),
        .o_sclk      (sclk),
        .o_rise_tick (w_rise),
        .o_fall_tick (w_fall)
    );

    assign w_illegal = (r_nbytes == 3'd0) || (r_nbytes > 3'(MAX_BYTES))
                     || ({1'b0, r_cs} >= (CSW + 1)'(NUM_CS));
    assign w_last    = (r_bit == BW'(nbits(ADDR_W, 32'(r_nbytes)) - 1));

    // Write bytes go out byte 0 first; unused and read slots shift out as zero
    always_comb begin
        w_data_field = '0;
        for (int k = 0; k < MAX_BYTES; k++) begin
            if (r_write && (k < int'(r_nbytes))) begin
                w_data_field[8*(MAX_BYTES-1-k) +: 8] = r_wdata[8*k +: 8];
            end
        end
    end

    // First received byte sits highest in r_rx; map it to byte 0 of the response
    always_comb begin
        w_rdata = '0;
        for (int k = 0; k < MAX_BYTES; k++) begin
            if (k < int'(r_nbytes)) begin
                w_rdata[8*k +: 8] = r_rx[8*(int'(r_nbytes)-1-k) +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_next = CHECK;
            CHECK:   w_next = w_illegal ? DONE : SETUP;
            SETUP:   w_next = SHIFT;
            SHIFT:   if (w_fall && w_last) w_next = HOLD;
            HOLD:    w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (r_state == IDLE);
        rsp_valid = (r_state == DONE);
        rsp_err   = (r_state == DONE) && r_err;
        w_clk_en  = (r_state == SHIFT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_write  <= 1'b0;
            r_cs     <= '0;
            r_addr   <= '0;
            r_nbytes <= '0;
            r_wdata  <= '0;
            r_err    <= 1'b0;
            r_shift  <= '0;
            r_rx     <= '0;
            r_bit    <= '0;
            r_cs_n   <= '1;
            r_rdata  <= '0;
        end else begin
            // Select decoded from the next state so cs_n is a clean register output
            if (w_next == SETUP || w_next == SHIFT || w_next == HOLD) begin
                r_cs_n <= ~(NUM_CS'(1) << r_cs);
            end else begin
                r_cs_n <= '1;
            end
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_write  <= req_write;
                        r_cs     <= req_cs;
                        r_addr   <= req_addr;
                        r_nbytes <= req_nbytes;
                        r_wdata  <= req_wdata;
                    end
                end
                CHECK: begin
                    r_err <= w_illegal;
                    r_rx  <= '0;
                    r_bit <= '0;
                    if (w_illegal) begin
                        r_rdata <= '0;
                    end else begin
                        r_shift <= {(r_write ? SPI_CMD_WRITE : SPI_CMD_READ), r_addr, w_data_field};
                    end
                end
                SHIFT: begin
                    if (w_rise) begin
                        r_rx <= {r_rx[30:0], miso};
                    end
                    if (w_fall) begin
                        r_shift <= r_shift << 1;
                        r_bit   <= r_bit + BW'(1);
                    end
                end
                HOLD: begin
                    r_rdata <= r_write ? 32'd0 : w_rdata;
                end
                default: ;
            endcase
        end
    end

    assign mosi      = r_shift[SR_W-1];
    assign cs_n      = r_cs_n;
    assign rsp_rdata = r_rdata;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// tb/tb_spi_mem_ctrl.sv - directed bench for spi_mem_ctrl with DIV=1 and DIV=2 instances and a SPI slave model
module tb_spi_mem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, req_valid, req_write, miso, sel;
    logic [1:0]  req_cs;
    logic [23:0] req_addr;
    logic [2:0]  req_nbytes;
    logic [31:0] req_wdata;

    logic        a_ready, a_valid, a_err, a_sclk, a_mosi;
    logic [31:0] a_rdata;
    logic [1:0]  a_cs_n;
    logic        b_ready, b_valid, b_err, b_sclk, b_mosi;
    logic [31:0] b_rdata;
    logic [1:0]  b_cs_n;

    logic        req_ready, rsp_valid, rsp_err, sclk, mosi;
    logic [31:0] rsp_rdata;
    logic [1:0]  cs_n;

    spi_mem_ctrl #(.NUM_CS(2), .ADDR_W(24), .DIV(1), .MAX_BYTES(4)) u_d1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid && !sel), .req_ready(a_ready),
        .req_write(req_write), .req_cs(req_cs[0:0]), .req_addr(req_addr),
        .req_nbytes(req_nbytes), .req_wdata(req_wdata), .rsp_valid(a_valid),
        .rsp_err(a_err), .rsp_rdata(a_rdata), .sclk(a_sclk), .mosi(a_mosi),
        .miso(miso), .cs_n(a_cs_n)
    );

    spi_mem_ctrl #(.NUM_CS(2), .ADDR_W(24), .DIV(2), .MAX_BYTES(4), .CSW(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid && sel), .req_ready(b_ready),
        .req_write(req_write), .req_cs(req_cs), .req_addr(req_addr),
        .req_nbytes(req_nbytes), .req_wdata(req_wdata), .rsp_valid(b_valid),
        .rsp_err(b_err), .rsp_rdata(b_rdata), .sclk(b_sclk), .mosi(b_mosi),
        .miso(miso), .cs_n(b_cs_n)
    );

    assign req_ready = sel ? b_ready : a_ready;
    assign rsp_valid = sel ? b_valid : a_valid;
    assign rsp_err   = sel ? b_err   : a_err;
    assign rsp_rdata = sel ? b_rdata : a_rdata;
    assign sclk      = sel ? b_sclk  : a_sclk;
    assign mosi      = sel ? b_mosi  : a_mosi;
    assign cs_n      = sel ? b_cs_n  : a_cs_n;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          res_wait, res_lat, res_cs_low, res_hi, res_rise;
    logic [1:0]  res_cs;
    logic [31:0] res_rdata;
    logic        res_err;
    logic [63:0] res_mosi;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_req(input logic s, input logic wr, input logic [1:0] cs,
                           input logic [23:0] addr, input logic [2:0] nb, input logic [31:0] wd,
                           input logic [63:0] slave, input bit hold, input int abort_bit);
        logic       psclk;
        logic [1:0] pcs;
        int         idx;
        int         c;
        sel = s; req_write = wr; req_cs = cs; req_addr = addr;
        req_nbytes = nb; req_wdata = wd; req_valid = 1'b1;
        res_wait = 0; res_lat = 0; res_cs_low = 0; res_hi = 0; res_rise = 0;
        res_cs = 2'b11; res_rdata = '0; res_err = 1'b0; res_mosi = '0;
        psclk = 1'b0; pcs = 2'b11; idx = 0; c = 0;
        #1;
        while (!req_ready && res_wait < 50) begin
            @(negedge clk);
            res_wait++;
        end
        chk("handshake_ready", 64'(req_ready), 1);
        while (c < 600) begin
            @(negedge clk);
            c++;
            if (c == 1 && !hold) req_valid = 1'b0;
            if (c == 10 && hold) begin
                req_addr = 24'hFFFFFF; req_write = ~wr; req_nbytes = 3'd0;
            end
            if (rsp_valid) begin
                res_lat = c; res_err = rsp_err; res_rdata = rsp_rdata;
                break;
            end
            if (cs_n != 2'b11) begin
                res_cs_low++;
                res_cs = cs_n;
            end
            if (sclk) res_hi++;
            if (sclk && !psclk) begin
                res_rise++;
                res_mosi = {res_mosi[62:0], mosi};
            end
            if (cs_n != 2'b11 && pcs == 2'b11) idx = 0;
            else if (psclk && !sclk) idx++;
            miso = (idx < 64) ? slave[63-idx] : 1'b0;
            psclk = sclk;
            pcs = cs_n;
            if (abort_bit != 0 && res_rise == abort_bit) begin
                rst_n = 1'b0;
                @(negedge clk);
                chk("abort_cs_n", 64'(cs_n), 'b11);
                chk("abort_sclk", 64'(sclk), 0);
                chk("abort_ready", 64'(req_ready), 1);
                chk("abort_rsp_valid", 64'(rsp_valid), 0);
                rst_n = 1'b1;
                req_valid = 1'b0;
                return;
            end
        end
        chk("rsp_seen", 64'(res_lat != 0), 1);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; sel = 1'b0; req_write = 1'b0; req_cs = '0;
        req_addr = '0; req_nbytes = '0; req_wdata = '0; miso = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(req_ready), 1);
        chk("rst_rsp_valid", 64'(rsp_valid), 0);
        chk("rst_rsp_err", 64'(rsp_err), 0);
        chk("rst_rdata", 64'(rsp_rdata), 0);
        chk("rst_sclk", 64'(sclk), 0);
        chk("rst_mosi", 64'(mosi), 0);
        chk("rst_cs_n", 64'(cs_n), 'b11);
        sel = 1'b1;
        #1;
        chk("rst_cs_n_div2", 64'(cs_n), 'b11);
        chk("rst_ready_div2", 64'(req_ready), 1);
        sel = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        run_req(1'b0, 1'b0, 2'd0, 24'h000104, 3'd4, 32'h0, 64'h00000000_11223344, 1'b0, 0);
        chk("rd4_latency", 64'(res_lat), 132);
        chk("rd4_rdata", 64'(res_rdata), 'h44332211);
        chk("rd4_err", 64'(res_err), 0);
        chk("rd4_cs_n", 64'(res_cs), 'b10);
        chk("rd4_cs_low", 64'(res_cs_low), 130);
        chk("rd4_bits", 64'(res_rise), 64);
        chk("rd4_mosi", res_mosi, 64'h03000104_00000000);

        run_req(1'b1, 1'b1, 2'd1, 24'h00ABCD, 3'd2, 32'hDEADBEEF, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 0);
        chk("wr_latency", 64'(res_lat), 196);
        chk("wr_cs_n", 64'(res_cs), 'b01);
        chk("wr_cs_low", 64'(res_cs_low), 194);
        chk("wr_sclk_high", 64'(res_hi), 96);
        chk("wr_bits", 64'(res_rise), 48);
        chk("wr_mosi", res_mosi, 64'h00000200_ABCDEFBE);
        chk("wr_err", 64'(res_err), 0);
        chk("wr_rdata", 64'(res_rdata), 0);

        run_req(1'b0, 1'b0, 2'd1, 24'h123456, 3'd1, 32'h0, 64'h00000000_80000000, 1'b0, 0);
        chk("rd1_latency", 64'(res_lat), 84);
        chk("rd1_rdata", 64'(res_rdata), 'h80);
        chk("rd1_cs_n", 64'(res_cs), 'b01);
        chk("rd1_mosi", res_mosi, 64'h00000003_12345600);

        run_req(1'b0, 1'b0, 2'd0, 24'h000040, 3'd0, 32'h0, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 0);
        chk("nb0_latency", 64'(res_lat), 2);
        chk("nb0_err", 64'(res_err), 1);
        chk("nb0_rdata", 64'(res_rdata), 0);
        chk("nb0_cs_low", 64'(res_cs_low), 0);
        chk("nb0_sclk_high", 64'(res_hi), 0);

        run_req(1'b1, 1'b0, 2'd0, 24'h000040, 3'd5, 32'h0, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 0);
        chk("nb5_latency", 64'(res_lat), 2);
        chk("nb5_err", 64'(res_err), 1);
        chk("nb5_cs_low", 64'(res_cs_low), 0);
        chk("nb5_sclk_high", 64'(res_hi), 0);

        run_req(1'b1, 1'b1, 2'd2, 24'h000040, 3'd1, 32'h55, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 0);
        chk("cs2_latency", 64'(res_lat), 2);
        chk("cs2_err", 64'(res_err), 1);
        chk("cs2_cs_low", 64'(res_cs_low), 0);
        chk("cs2_sclk_high", 64'(res_hi), 0);

        run_req(1'b0, 1'b0, 2'd0, 24'h000010, 3'd2, 32'h0, 64'h00000000_A55A0000, 1'b1, 0);
        chk("b2b_a_latency", 64'(res_lat), 100);
        chk("b2b_a_rdata", 64'(res_rdata), 'h5AA5);
        chk("b2b_a_mosi", res_mosi, 64'h00000300_00100000);
        run_req(1'b0, 1'b0, 2'd1, 24'h000020, 3'd3, 32'h0, 64'h00000000_01020300, 1'b0, 0);
        chk("b2b_b_wait", 64'(res_wait), 1);
        chk("b2b_b_latency", 64'(res_lat), 116);
        chk("b2b_b_rdata", 64'(res_rdata), 'h030201);
        chk("b2b_b_cs_n", 64'(res_cs), 'b01);

        run_req(1'b0, 1'b0, 2'd0, 24'h000200, 3'd4, 32'h0, 64'h00000000_DEADDEAD, 1'b0, 20);
        @(negedge clk);
        chk("post_abort_rdata", 64'(rsp_rdata), 0);
        run_req(1'b0, 1'b0, 2'd0, 24'h000300, 3'd4, 32'h0, 64'h00000000_CAFEBABE, 1'b0, 0);
        chk("recover_latency", 64'(res_lat), 132);
        chk("recover_rdata", 64'(res_rdata), 'hBEBAFECA);
        chk("recover_mosi", res_mosi, 64'h03000300_00000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
